// File: rtl/rng_share_sched_pkg.sv
// ============================================================================
// Module      : rng_pkg
// Description : Shared constants, FSM encoding and LFSR byte-step functions
//               for the shared random-byte front end.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rng_pkg;

    localparam int                LFSR_W       = 23;
    localparam int                BYTE_W       = 8;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 23'h000001;

    typedef enum logic [0:0] {
        WARM  = 1'b0,
        SERVE = 1'b1
    } fsm_t;

    // Byte bits 5..0 chain off the bit two places above, so a loop covers them.
    function automatic logic [BYTE_W-1:0] lfsr_byte(input logic [LFSR_W-1:0] s);
        logic [BYTE_W-1:0] b;
        b[7] = s[22] ^ s[1];
        b[6] = s[21] ^ s[0];
        for (int k = 5; k >= 0; k--) begin
            b[k] = s[15+k] ^ b[k+2];
        end
        return b;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[22] ^ s[1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rng_lfsr23_core.sv
// ============================================================================
// Module      : rng_lfsr23_core
// Description : 23-bit Fibonacci LFSR state with load and step; the output
//               byte is combinational from the current (pre-step) state.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rng_lfsr23_core
    import rng_pkg::*;
#(
    parameter logic [22:0] RESET_SEED = rng_pkg::SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [BYTE_W-1:0] rnd_byte,
    output logic [LFSR_W-1:0] lfsr_state
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RESET_SEED;
        end else if (load) begin
            r_state <= load_val;
        end else if (step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign lfsr_state = r_state;
    assign rnd_byte   = lfsr_byte(r_state);

endmodule

`default_nettype wire

// File: rtl/rng_share_sched.sv
// ============================================================================
// Module      : rng_share_sched
// Description : Seeds and warms up the LFSR byte generator, then hands each
//               byte to exactly one requester in round-robin order.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rng_share_sched
    import rng_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter int          WARMUP       = 32,
    parameter logic [22:0] SEED_DEFAULT = rng_pkg::SEED_DEFAULT,
    localparam int         IDW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic              rnd_valid,
    output logic [BYTE_W-1:0] rnd_data,
    output logic [IDW-1:0]    rnd_id,
    output logic              ready
);

    generate
        if (WARMUP < 0 || WARMUP > 65535) begin : g_bad_warmup
            $error("rng_share_sched: WARMUP must be within 0..65535");
        end
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
            $error("rng_share_sched: N_REQ must be within 2..8");
        end
    endgenerate

    localparam logic [15:0]      c_warm_init = 16'(WARMUP);
    localparam logic [N_REQ-1:0] c_gnt_one   = N_REQ'(1);

    fsm_t              r_state;
    fsm_t              w_state_nxt;
    logic [15:0]       r_warm_cnt;
    logic [15:0]       w_cnt_nxt;
    logic [IDW-1:0]    r_rr_ptr;
    logic [IDW-1:0]    w_rr_nxt;
    logic [N_REQ-1:0]  r_gnt;
    logic              r_valid;
    logic [BYTE_W-1:0] r_data;
    logic [IDW-1:0]    r_id;
    logic              w_step;
    logic              w_grant;
    logic              w_any;
    logic [IDW-1:0]    w_off;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_pick;
    logic [2*N_REQ-1:0] w_req2;
    logic [BYTE_W-1:0] w_byte;
    logic [LFSR_W-1:0] w_lfsr_state;
    logic [LFSR_W-1:0] w_load_val;

    // An all-zero seed would lock the LFSR, so it is replaced by the default.
    assign w_load_val = (seed_in == '0) ? SEED_DEFAULT : seed_in;

    rng_lfsr23_core #(
        .RESET_SEED (SEED_DEFAULT)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (seed_load),
        .load_val   (w_load_val),
        .step       (w_step),
        .rnd_byte   (w_byte),
        .lfsr_state (w_lfsr_state)
    );

    // Rotate requests so bit k is requester (rr + k) mod N; lowest set k wins.
    assign w_req2 = {req, req} >> r_rr_ptr;

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_req2[k]) begin
                w_any = 1'b1;
                w_off = IDW'(k);
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (IDW+1)'(N_REQ)) begin
            w_sum = w_sum - (IDW+1)'(N_REQ);
        end
        w_pick   = w_sum[IDW-1:0];
        w_rr_nxt = (w_pick == IDW'(N_REQ - 1)) ? '0 : w_pick + 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_warm_cnt;
        w_step      = 1'b0;
        w_grant     = 1'b0;
        if (seed_load) begin
            w_state_nxt = WARM;
            w_cnt_nxt   = c_warm_init;
        end else begin
            case (r_state)
                WARM: begin
                    if (r_warm_cnt == '0) begin
                        w_state_nxt = SERVE;
                    end else begin
                        w_step    = 1'b1;
                        w_cnt_nxt = r_warm_cnt - 16'd1;
                    end
                end
                SERVE: begin
                    if (w_any) begin
                        w_grant = 1'b1;
                        w_step  = 1'b1;
                    end
                end
                default: w_state_nxt = WARM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= WARM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_warm_cnt <= c_warm_init;
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_valid    <= 1'b0;
            r_data     <= 8'hFF;
            r_id       <= '0;
        end else begin
            r_warm_cnt <= w_cnt_nxt;
            r_gnt      <= '0;
            r_valid    <= w_grant;
            if (w_grant) begin
                r_gnt    <= c_gnt_one << w_pick;
                r_id     <= w_pick;
                r_data   <= w_byte;
                r_rr_ptr <= w_rr_nxt;
            end
        end
    end

    assign gnt       = r_gnt;
    assign rnd_valid = r_valid;
    assign rnd_data  = r_data;
    assign rnd_id    = r_id;
    assign ready     = (r_state == SERVE);

endmodule

`default_nettype wire

// File: tb/tb_rng_share_sched.sv
// ============================================================================
// Module      : tb_rng_share_sched
// Description : Directed bench for rng_share_sched with WARMUP = 0, 32 and 4.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rng_share_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_load = 1'b0;
    logic [22:0] seed_in = '0;
    logic [3:0]  req = '0;

    logic [3:0] gnt0, gnt32, gnt4;
    logic       valid0, valid32, valid4;
    logic [7:0] data0, data32, data4;
    logic [1:0] id0, id32, id4;
    logic       rdy0, rdy32, rdy4;
    logic [22:0] st0, st32, st4;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;
    logic [22:0] m_s;

    always #5 clk = ~clk;

    rng_share_sched #(.N_REQ(4), .WARMUP(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .req(req),
        .gnt(gnt0), .rnd_valid(valid0), .rnd_data(data0), .rnd_id(id0), .ready(rdy0));
    rng_share_sched #(.N_REQ(4), .WARMUP(32)) u_d32 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .req(req),
        .gnt(gnt32), .rnd_valid(valid32), .rnd_data(data32), .rnd_id(id32), .ready(rdy32));
    rng_share_sched #(.N_REQ(4), .WARMUP(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .req(req),
        .gnt(gnt4), .rnd_valid(valid4), .rnd_data(data4), .rnd_id(id4), .ready(rdy4));

    assign st0  = u_d0.u_core.lfsr_state;
    assign st32 = u_d32.u_core.lfsr_state;
    assign st4  = u_d4.u_core.lfsr_state;

    function automatic logic [7:0] m_byte(input logic [22:0] s);
        logic b7, b6, b5, b4, b3, b2, b1, b0;
        b7 = s[22] ^ s[1];
        b6 = s[21] ^ s[0];
        b5 = s[20] ^ b7;
        b4 = s[19] ^ b6;
        b3 = s[18] ^ b5;
        b2 = s[17] ^ b4;
        b1 = s[16] ^ b3;
        b0 = s[15] ^ b2;
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic logic [22:0] m_next(input logic [22:0] s);
        return {s[21:0], s[22] ^ s[1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (armed) begin
            chk("state0_nonzero",  32'(st0  != '0), 32'd1);
            chk("state32_nonzero", 32'(st32 != '0), 32'd1);
            chk("state4_nonzero",  32'(st4  != '0), 32'd1);
        end
    endtask

    task automatic get_outs(input int sel, output logic [3:0] g, output logic v,
                            output logic [1:0] id, output logic [7:0] d, output logic r);
        case (sel)
            0:       begin g = gnt0;  v = valid0;  id = id0;  d = data0;  r = rdy0;  end
            1:       begin g = gnt32; v = valid32; id = id32; d = data32; r = rdy32; end
            default: begin g = gnt4;  v = valid4;  id = id4;  d = data4;  r = rdy4;  end
        endcase
    endtask

    task automatic chk_reset(input string tag, input int sel);
        logic [3:0] g; logic v; logic [1:0] id; logic [7:0] d; logic r;
        get_outs(sel, g, v, id, d, r);
        chk({tag, "_gnt"},   32'(g),  32'h0);
        chk({tag, "_valid"}, 32'(v),  32'h0);
        chk({tag, "_data"},  32'(d),  32'hFF);
        chk({tag, "_id"},    32'(id), 32'h0);
        chk({tag, "_ready"}, 32'(r),  32'h0);
    endtask

    // Compares the current grant against the model and advances the model.
    task automatic expect_grant(input string tag, input int sel, input int exp_id);
        logic [3:0] g; logic v; logic [1:0] id; logic [7:0] d; logic r;
        get_outs(sel, g, v, id, d, r);
        chk({tag, "_gnt"},   32'(g),  32'(1 << exp_id));
        chk({tag, "_valid"}, 32'(v),  32'h1);
        chk({tag, "_id"},    32'(id), 32'(exp_id));
        chk({tag, "_data"},  32'(d),  32'(m_byte(m_s)));
        m_s = m_next(m_s);
    endtask

    task automatic wait_grant(input string tag, input int sel, input int budget);
        logic [3:0] g; logic v; logic [1:0] id; logic [7:0] d; logic r;
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            get_outs(sel, g, v, id, d, r);
            got = (g != '0);
        end
        chk({tag, "_grant_timeout"}, 32'(got), 32'h1);
    endtask

    initial begin
        // Single requester, WARMUP = 0
        rst_n = 1'b0; req = 4'b0000;
        tick();
        armed = 1'b1;
        chk_reset("t1_rst0", 0);
        chk_reset("t1_rst32", 1);
        chk_reset("t1_rst4", 2);
        chk("t1_rst_state", 32'(st0), 32'h000001);
        rst_n = 1'b1; req = 4'b0001;
        tick();
        chk("t1_ready", 32'(rdy0), 32'h1);
        chk("t1_no_gnt_warm", 32'(gnt0), 32'h0);
        m_s = 23'h000001;
        tick();
        chk("t1_b0_hand", 32'(data0), 32'h55);
        chk("t1_st1", 32'(st0), 32'h000002);
        expect_grant("t1_g0", 0, 0);
        tick();
        chk("t1_b1_hand", 32'(data0), 32'hAA);
        chk("t1_st2", 32'(st0), 32'h000005);
        expect_grant("t1_g1", 0, 0);
        tick();
        chk("t1_b2_hand", 32'(data0), 32'h55);
        expect_grant("t1_g2", 0, 0);

        // All four requesting, round robin over the same byte stream
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b1111;
        tick();
        m_s = 23'h000001;
        for (int k = 0; k < 8; k++) begin
            tick();
            expect_grant("t2_rr", 0, k % 4);
        end

        // WARMUP = 32 discards 32 bytes before the first grant
        rst_n = 1'b0; req = 4'b0011;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("t3_warm_gnt", 32'(gnt32), 32'h0);
            chk("t3_warm_ready", 32'(rdy32), 32'h0);
        end
        m_s = 23'h000001;
        for (int i = 0; i < 32; i++) m_s = m_next(m_s);
        wait_grant("t3", 1, 4);
        expect_grant("t3_first", 1, 0);
        tick();
        expect_grant("t3_second", 1, 1);

        // Zero seed mid-stream falls back to the default seed
        rst_n = 1'b0; req = 4'b0001;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        seed_load = 1'b1; seed_in = 23'h0;
        tick();
        seed_load = 1'b0;
        chk("t4_seed_gnt", 32'(gnt0), 32'h0);
        chk("t4_seed_valid", 32'(valid0), 32'h0);
        chk("t4_seed_ready", 32'(rdy0), 32'h0);
        chk("t4_seed_state", 32'(st0), 32'h000001);
        m_s = 23'h000001;
        wait_grant("t4", 0, 3);
        chk("t4_b0_hand", 32'(data0), 32'h55);
        expect_grant("t4_reseed", 0, 0);

        // Reseed coincident with requests, WARMUP = 4, rr pointer retained
        rst_n = 1'b0; req = 4'b0011;
        tick();
        rst_n = 1'b1;
        m_s = 23'h000001;
        for (int i = 0; i < 4; i++) m_s = m_next(m_s);
        wait_grant("t5a", 2, 8);
        expect_grant("t5_pre0", 2, 0);
        tick();
        expect_grant("t5_pre1", 2, 1);
        seed_load = 1'b1; seed_in = 23'h1234AB; req = 4'b1111;
        tick();
        seed_load = 1'b0;
        chk("t5_seed_gnt", 32'(gnt4), 32'h0);
        chk("t5_seed_valid", 32'(valid4), 32'h0);
        chk("t5_seed_ready", 32'(rdy4), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_warm_gnt", 32'(gnt4), 32'h0);
        end
        m_s = 23'h1234AB;
        for (int i = 0; i < 4; i++) m_s = m_next(m_s);
        wait_grant("t5b", 2, 3);
        expect_grant("t5_resume", 2, 2);
        tick();
        expect_grant("t5_next", 2, 3);

        // Reset during SERVE (d0) and WARM (d32), taking priority over seed_load
        rst_n = 1'b0; req = 4'b0000;
        tick();
        rst_n = 1'b1; req = 4'b0001;
        repeat (6) tick();
        chk("t6_pre_ready32", 32'(rdy32), 32'h0);
        rst_n = 1'b0; seed_load = 1'b1; seed_in = 23'h1234AB;
        tick();
        seed_load = 1'b0;
        chk_reset("t6_serve_rst", 0);
        chk_reset("t6_warm_rst", 1);
        chk("t6_state0", 32'(st0), 32'h000001);
        chk("t6_state32", 32'(st32), 32'h000001);
        rst_n = 1'b1;
        m_s = 23'h000001;
        tick();
        tick();
        chk("t6_b0_hand", 32'(data0), 32'h55);
        expect_grant("t6_restart", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/rng_share_sched.md
Name: rng_share_sched

Overview:
- Arbitrated front end for the 23-bit Fibonacci LFSR byte generator used by the Monte Carlo Hawkes datapath.
- Owns seeding and post-seed warm-up of the generator.
- Shares its 8-bit output stream among N_REQ consumers (event-time and mark samplers) with round-robin fairness.
- Every generated byte is delivered to exactly one consumer, never duplicated or dropped.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WARMUP, 32, generator steps discarded after every (re)seed, 0..65535.
- SEED_DEFAULT, 23'h000001, seed loaded at reset and substituted for an all-zero seed_in.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- seed_load  in  1  single-cycle pulse: reseed generator from seed_in.
- seed_in  in  23  seed value, sampled when seed_load=1.
- req  in  N_REQ  per-consumer request level; one byte per grant.
- gnt  out  N_REQ  one-hot grant, 1-cycle pulse, coincident with rnd_valid.
- rnd_valid  out  1  rnd_data/rnd_id valid this cycle.
- rnd_data  out  8  random byte.
- rnd_id  out  max(1,$clog2(N_REQ))  index of the granted consumer.
- ready  out  1  1 in SERVE state.

Behaviour:
- Generator step, from state s[22:0]:
  - b7=s22^s1, b6=s21^s0, b5=s20^b7, b4=s19^b6, b3=s18^b5, b2=s17^b4, b1=s16^b3, b0=s15^b2.
  - Byte = {b7..b0}; next state = {s[21:0], b7}.
  - The state steps only when enabled. The byte delivered is the one computed from the pre-step state.
- Reset (rst_n=0 at edge):
  - s=SEED_DEFAULT, state WARM, warm counter=WARMUP, rr pointer=0.
  - gnt=0, rnd_valid=0, rnd_data=8'hFF, rnd_id=0, ready=0.
- FSM states:
  - WARM:
    - Step the generator every cycle and decrement the counter; no grants; req ignored.
    - Counter==0 -> SERVE. With WARMUP=0, SERVE is entered on the first cycle after reset/seed.
  - SERVE:
    - Any req bit set -> choose the first set bit scanning from rr pointer upward with wrap.
    - On the next edge: gnt[i]=1, rnd_valid=1, rnd_id=i, rnd_data=byte; generator steps; rr pointer=(i+1) mod N_REQ.
    - No req -> no step, rnd_valid=0, rnd_data holds its last value.
- Latency: req sampled at edge t; grant and data are registered outputs visible after edge t. Throughput is one byte per cycle total.
- A consumer holding req high continuously receives one grant per round-robin turn. The consumer drops req on the cycle it sees its last needed gnt.
- A req bit that drops before being granted is never granted.
- seed_load=1 (any state, including mid-warm-up or mid-stream):
  - s=seed_in, or SEED_DEFAULT if seed_in==0, because the all-zero state locks up.
  - Counter=WARMUP, state WARM, and gnt/rnd_valid cleared on that edge.
  - seed_load has priority over req in the same cycle. The rr pointer is kept.
- rst_n has priority over seed_load.
- The all-zero generator state is unreachable; the bench asserts this.
- Warm counter width: 16 bits. WARMUP > 65535 is a parameter error; fail elaboration.

Decomposition:
- Shared package rng_pkg holds:
  - LFSR_W=23, BYTE_W=8, SEED_DEFAULT constant.
  - FSM enum {WARM, SERVE}.
  - The byte-step function, so models and RTL share one definition.
- Sub-module rng_lfsr23_core:
  - Inputs: clk, rst_n, load, load_val, step.
  - Outputs: byte (combinational from state) and state.
  - The scheduler instantiates one core and owns the FSM, counter and round-robin arbiter.

Test Plan:
- WARMUP=0, reset, req=4'b0001 held:
  - rnd_data sequence 8'h55, 8'hAA, 8'h55, ...
  - Generator state 000001 -> 000002 -> 000005.
  - gnt=0001 every cycle; rnd_id=0.
- WARMUP=0, req=4'b1111 held 8 cycles:
  - Grants 0,1,2,3,0,1,2,3.
  - Bytes identical to the single-requester sequence, in order.
  - No byte repeated or skipped.
- WARMUP=32, reset:
  - ready=0 and gnt=0 for 32 cycles despite req=4'b0011.
  - The first granted byte equals the 33rd model byte.
- seed_load with seed_in=0 mid-stream (WARMUP=0):
  - gnt cleared that cycle.
  - Next byte is 8'h55 (SEED_DEFAULT path).
- seed_load coincident with req in SERVE, WARMUP=4:
  - No grant that cycle; 4 grant-free cycles follow, then grants resume at the retained rr pointer.
- Reset asserted during WARM and during SERVE:
  - All outputs return to reset values on the next edge.
  - The sequence restarts from SEED_DEFAULT.
